mem_port_arbiter: RTL

//  Sequences one shared single-port memory between instruction fetch and the

---
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the load/store path.
// Optional macro ARB_ROUND_ROBIN_EN: alternate the winner on contested grants (default: data always wins).
module mem_port_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ifetch_req_i,
    input  logic [ADDR_WIDTH-1:0] ifetch_addr_i,
    output logic [DATA_WIDTH-1:0] ifetch_data_o,
    output logic                  ifetch_ack_o,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    output logic [DATA_WIDTH-1:0] data_rdata_o,
    output logic                  data_ack_o,
    output logic                  stall_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic                  mem_re_o,
    output logic                  mem_we_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] count;
    logic       owner_data;
    logic       op_write;
    logic       data_req;
    logic       grant_data;
    logic       grant;
`ifdef ARB_ROUND_ROBIN_EN
    logic       last_data;
`endif

    assign data_req = mem_read_i | mem_write_i;
    assign grant    = (state == IDLE) && (data_req || ifetch_req_i);

    // Winner selection; only meaningful while grant is high.
    always_comb begin
        grant_data = data_req;
`ifdef ARB_ROUND_ROBIN_EN
        if (data_req && ifetch_req_i) begin
            grant_data = ~last_data;
        end
`endif
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant) state_next = ACCESS;
            ACCESS:  if (count == 4'd0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count         <= 4'd0;
            owner_data    <= 1'b0;
            op_write      <= 1'b0;
            mem_addr_o    <= '0;
            mem_wdata_o   <= '0;
            ifetch_data_o <= '0;
            data_rdata_o  <= '0;
            ifetch_ack_o  <= 1'b0;
            data_ack_o    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_data     <= 1'b0;
`endif
        end else begin
            ifetch_ack_o <= 1'b0;
            data_ack_o   <= 1'b0;
            if (grant) begin
                mem_addr_o <= grant_data ? data_addr_i : ifetch_addr_i;
                if (grant_data) begin
                    mem_wdata_o <= data_wdata_i;
                end
                // A simultaneous read+write is carried out as a write only.
                op_write   <= grant_data & mem_write_i;
                owner_data <= grant_data;
                count      <= WAIT_CNT;
`ifdef ARB_ROUND_ROBIN_EN
                if (data_req && ifetch_req_i) begin
                    last_data <= grant_data;
                end
`endif
            end
            if (state == ACCESS) begin
                if (count != 4'd0) begin
                    count <= count - 4'd1;
                end else begin
                    ifetch_ack_o <= ~owner_data;
                    data_ack_o   <= owner_data;
                    if (!op_write) begin
                        if (owner_data) begin
                            data_rdata_o <= mem_rdata_i;
                        end else begin
                            ifetch_data_o <= mem_rdata_i;
                        end
                    end
                end
            end
        end
    end

    assign mem_re_o = (state == ACCESS) && !op_write;
    assign mem_we_o = (state == ACCESS) && op_write && (count == 4'd0);
    // Gated by reset so that every output reads 0 while reset is held.
    assign stall_o  = reset && (ifetch_req_i || data_req) && !(ifetch_ack_o || data_ack_o);

endmodule
